// File: rtl/branch_resolve_queue.sv
// Multi-lane branch resolution: oldest-mispredict redirect, predictor training
// FIFO with valid/ready drain, and saturating branch/mispredict counters.

module brq_lane #(
  parameter int PC_WIDTH = 32
) (
  input  logic                valid_i,
  input  logic                taken_i,
  input  logic                pred_valid_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic [PC_WIDTH-1:0] target_i,
  input  logic [PC_WIDTH-1:0] pred_next_i,
  output logic [PC_WIDTH-1:0] actual_next_o,
  output logic                mispred_o
);
  assign actual_next_o = taken_i ? target_i : pc_i + PC_WIDTH'(4);
  // Non-branches are checked too: a BTB alias on a plain instruction must redirect.
  assign mispred_o = valid_i & (pred_valid_i ? (pred_next_i != actual_next_o) : taken_i);
endmodule

module branch_resolve_queue #(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 8,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_LANES-1:0]          resValid,
  input  logic [NUM_LANES-1:0]          resIsBranch,
  input  logic [NUM_LANES*PC_WIDTH-1:0] resPc,
  input  logic [NUM_LANES-1:0]          resTaken,
  input  logic [NUM_LANES*PC_WIDTH-1:0] resTarget,
  input  logic [NUM_LANES-1:0]          resPredValid,
  input  logic [NUM_LANES*PC_WIDTH-1:0] resPredNextPc,
  output logic                          stall,
  output logic                          redirectValid,
  output logic [PC_WIDTH-1:0]           redirectPc,
  output logic                          updValid,
  input  logic                          updReady,
  output logic [PC_WIDTH-1:0]           updPc,
  output logic [PC_WIDTH-1:0]           updTarget,
  output logic                          updTaken,
  output logic [CNT_WIDTH-1:0]          branchCount,
  output logic [CNT_WIDTH-1:0]          mispredCount
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int ENQ_W = $clog2(NUM_LANES + 1);
  localparam int SUM_W = CNT_WIDTH + ENQ_W;

  logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d, count;
  logic                 redirectValid_q, redirectValid_d;
  logic [PC_WIDTH-1:0]  redirectPc_q, redirectPc_d;
  logic [CNT_WIDTH-1:0] branchCount_q, branchCount_d, mispredCount_q, mispredCount_d;
  logic [PC_WIDTH-1:0]  mem_pc_q  [DEPTH];
  logic [PC_WIDTH-1:0]  mem_tgt_q [DEPTH];
  logic                 mem_tk_q  [DEPTH];

  logic [NUM_LANES-1:0]               mispred, enq;
  logic [NUM_LANES-1:0][PC_WIDTH-1:0] actual_next;
  logic [PTR_W-1:0]                   slot [NUM_LANES];
  logic [ENQ_W-1:0]                   n_enq;
  logic [SUM_W-1:0]                   bc_sum;
  logic                               consume, any_mis, older_mis, pop;
  logic [PC_WIDTH-1:0]                mis_pc;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      brq_lane #(.PC_WIDTH(PC_WIDTH)) u_lane (
        .valid_i      (resValid[g]),
        .taken_i      (resTaken[g]),
        .pred_valid_i (resPredValid[g]),
        .pc_i         (resPc[g*PC_WIDTH +: PC_WIDTH]),
        .target_i     (resTarget[g*PC_WIDTH +: PC_WIDTH]),
        .pred_next_i  (resPredNextPc[g*PC_WIDTH +: PC_WIDTH]),
        .actual_next_o(actual_next[g]),
        .mispred_o    (mispred[g])
      );
    end
  endgenerate

  // Stall looks only at registered occupancy, so a same-cycle pop never helps.
  assign count   = wr_q - rd_q;
  assign stall   = count > PTR_W'(DEPTH - NUM_LANES);
  assign consume = ~stall & ~redirectValid_q;
  assign any_mis = consume & (|mispred);
  assign updValid = count != '0;
  assign pop     = updValid & updReady;

  always_comb begin
    older_mis = 1'b0;
    n_enq     = '0;
    enq       = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      slot[i] = wr_q + PTR_W'(n_enq);
      enq[i]  = consume & ~older_mis & resValid[i] & resIsBranch[i];
      n_enq   = n_enq + ENQ_W'(enq[i]);
      older_mis = older_mis | mispred[i];
    end
  end

  always_comb begin
    mis_pc = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (mispred[i]) mis_pc = actual_next[i];
  end

  always_comb begin
    wr_d            = wr_q + PTR_W'(n_enq);
    rd_d            = rd_q + PTR_W'(pop);
    redirectValid_d = any_mis;
    redirectPc_d    = any_mis ? mis_pc : redirectPc_q;
    bc_sum          = SUM_W'(branchCount_q) + SUM_W'(n_enq);
    branchCount_d   = (bc_sum[SUM_W-1:CNT_WIDTH] != '0) ? '1 : bc_sum[CNT_WIDTH-1:0];
    mispredCount_d  = (any_mis && mispredCount_q != '1) ? mispredCount_q + 1'b1 : mispredCount_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q            <= '0;
      rd_q            <= '0;
      redirectValid_q <= 1'b0;
      redirectPc_q    <= '0;
      branchCount_q   <= '0;
      mispredCount_q  <= '0;
    end else begin
      wr_q            <= wr_d;
      rd_q            <= rd_d;
      redirectValid_q <= redirectValid_d;
      redirectPc_q    <= redirectPc_d;
      branchCount_q   <= branchCount_d;
      mispredCount_q  <= mispredCount_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (enq[i]) begin
        mem_pc_q[slot[i][IDX_W-1:0]]  <= resPc[i*PC_WIDTH +: PC_WIDTH];
        mem_tgt_q[slot[i][IDX_W-1:0]] <= resTarget[i*PC_WIDTH +: PC_WIDTH];
        mem_tk_q[slot[i][IDX_W-1:0]]  <= resTaken[i];
      end
    end
  end

  assign redirectValid = redirectValid_q;
  assign redirectPc    = redirectPc_q;
  assign branchCount   = branchCount_q;
  assign mispredCount  = mispredCount_q;
  assign updPc         = updValid ? mem_pc_q[rd_q[IDX_W-1:0]]  : '0;
  assign updTarget     = updValid ? mem_tgt_q[rd_q[IDX_W-1:0]] : '0;
  assign updTaken      = updValid & mem_tk_q[rd_q[IDX_W-1:0]];
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench: a transaction-level model predicts records/redirects into
// queues; a negedge monitor pops and compares whenever the DUT presents them.

module tb_branch_resolve_queue;
  localparam int NL = 2;
  localparam int DP = 8;
  localparam int PW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NL-1:0]    resValid = '0, resIsBranch = '0, resTaken = '0, resPredValid = '0;
  logic [NL*PW-1:0] resPc = '0, resTarget = '0, resPredNextPc = '0;
  logic             updReady = 1'b0;
  logic             stall, redirectValid, updValid, updTaken;
  logic [PW-1:0]    redirectPc, updPc, updTarget;
  logic [CW-1:0]    branchCount, mispredCount;

  branch_resolve_queue #(.NUM_LANES(NL), .DEPTH(DP), .PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .resValid(resValid), .resIsBranch(resIsBranch), .resPc(resPc), .resTaken(resTaken),
    .resTarget(resTarget), .resPredValid(resPredValid), .resPredNextPc(resPredNextPc),
    .stall(stall), .redirectValid(redirectValid), .redirectPc(redirectPc),
    .updValid(updValid), .updReady(updReady), .updPc(updPc), .updTarget(updTarget),
    .updTaken(updTaken), .branchCount(branchCount), .mispredCount(mispredCount)
  );

  always #5 clk = ~clk;

  typedef struct { logic [PW-1:0] pc; logic tk; logic [PW-1:0] tg; } rec_t;
  rec_t          exp_rec[$];
  logic [PW-1:0] exp_redir[$];

  int  n_tests = 0, n_fail = 0;
  int  m_count = 0, m_bc = 0, m_mc = 0;
  bit  m_redir = 0, m_last_cons = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (updValid && updReady) begin
        n_tests++;
        if (exp_rec.size() == 0) begin
          n_fail++;
          $display("FAIL rec_unexpected: got pc %0h, none expected", updPc);
        end else begin
          rec_t e;
          e = exp_rec.pop_front();
          n_tests--;
          chk("rec_pc", updPc, e.pc);
          chk("rec_taken", updTaken, e.tk);
          chk("rec_target", updTarget, e.tg);
        end
      end
      if (redirectValid) begin
        if (exp_redir.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL redir_unexpected: got %0h, none expected", redirectPc);
        end else
          chk("redirect_pc", redirectPc, exp_redir.pop_front());
      end
    end
  end

  task automatic clear_lanes();
    resValid = '0; resIsBranch = '0; resTaken = '0; resPredValid = '0;
    resPc = '0; resTarget = '0; resPredNextPc = '0;
  endtask

  task automatic set_lane(input int i, input bit v, input bit br, input logic [PW-1:0] pc,
                          input bit tk, input logic [PW-1:0] tg, input bit pv, input logic [PW-1:0] pn);
    resValid[i] = v; resIsBranch[i] = br; resTaken[i] = tk; resPredValid[i] = pv;
    resPc[i*PW +: PW] = pc; resTarget[i*PW +: PW] = tg; resPredNextPc[i*PW +: PW] = pn;
  endtask

  // Called at posedge+1 with inputs set: check current state, then predict the edge.
  task automatic tick();
    bit cons, stop, redir, pop;
    int nenq;
    logic [PW-1:0] pc, act;
    rec_t r;
    chk("updValid", updValid, m_count > 0);
    chk("stall", stall, m_count > DP - NL);
    chk("redirectValid", redirectValid, m_redir);
    chk("branchCount", branchCount, m_bc);
    chk("mispredCount", mispredCount, m_mc);
    cons = !(m_count > DP - NL) && !m_redir;
    nenq = 0; stop = 0; redir = 0;
    if (cons) begin
      for (int i = 0; i < NL; i++) begin
        if (!stop) begin
          pc  = resPc[i*PW +: PW];
          act = resTaken[i] ? resTarget[i*PW +: PW] : pc + 32'd4;
          if (resValid[i] && resIsBranch[i]) begin
            r.pc = pc; r.tk = resTaken[i]; r.tg = resTarget[i*PW +: PW];
            exp_rec.push_back(r);
            nenq++;
          end
          if (resValid[i] && (resPredValid[i] ? resPredNextPc[i*PW +: PW] != act : resTaken[i])) begin
            exp_redir.push_back(act);
            redir = 1; stop = 1;
          end
        end
      end
    end
    pop = (m_count > 0) && updReady;
    m_count = m_count + nenq - int'(pop);
    m_bc = (m_bc + nenq > CMAX) ? CMAX : m_bc + nenq;
    if (redir) m_mc = (m_mc + 1 > CMAX) ? CMAX : m_mc + 1;
    m_redir = redir;
    m_last_cons = cons;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; updReady = 1'b0; clear_lanes();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rec.delete(); exp_redir.delete();
    m_count = 0; m_bc = 0; m_mc = 0; m_redir = 0;
  endtask

  task automatic drain();
    clear_lanes(); updReady = 1'b1;
    for (int c = 0; c < 40 && (m_count > 0 || m_redir); c++) tick();
    tick();
    chk("drain_records_left", exp_rec.size(), 0);
    chk("drain_redirects_left", exp_redir.size(), 0);
  endtask

  // Correctly predicted single branch on lane 0.
  task automatic good_branch(input logic [PW-1:0] pc, input bit tk);
    logic [PW-1:0] tg, nx;
    tg = pc + 32'h40;
    nx = tk ? tg : pc + 32'd4;
    set_lane(0, 1, 1, pc, tk, tg, 1, nx);
  endtask

  initial begin
    int sent;
    clear_lanes();
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    tick(); tick();
    chk("reset_updPc", updPc, 0);
    chk("reset_redirectPc", redirectPc, 0);

    // Correctly predicted taken branch plus a plain instruction.
    updReady = 1'b1;
    set_lane(0, 1, 1, 32'h100, 1, 32'h200, 1, 32'h200);
    set_lane(1, 1, 0, 32'h104, 0, 32'h0, 0, 32'h0);
    tick();
    clear_lanes();
    chk("s1_updPc", updPc, 32'h100);
    chk("s1_branchCount", branchCount, 1);
    tick();

    // Lane 0 mispredicts not-taken; lane 1 squashed; next-cycle lanes dropped.
    set_lane(0, 1, 1, 32'h100, 0, 32'h200, 1, 32'h200);
    set_lane(1, 1, 1, 32'h104, 1, 32'h300, 0, 32'h0);
    tick();
    chk("s2_redirectPc", redirectPc, 32'h104);
    set_lane(0, 1, 1, 32'h500, 1, 32'h600, 0, 32'h0);
    tick();
    clear_lanes();
    tick();
    drain();

    // Back-pressure: two branches per cycle with the consumer stalled.
    updReady = 1'b0;
    for (int c = 0; c < 8; c++) begin
      good_branch(32'h1000 + 32'(c * 16), c[0]);
      set_lane(1, 1, 1, 32'h1004 + 32'(c * 16), 0, 32'h0, 1, 32'h1008 + 32'(c * 16));
      tick();
    end
    chk("bp_stall", stall, 1);
    drain();
    chk("bp_stall_drop", stall, 0);

    // Wrap-around: 20 accepted single-branch records with ready toggling.
    do_reset();
    sent = 0;
    for (int c = 0; c < 200 && sent < 20; c++) begin
      clear_lanes();
      good_branch(32'h2000 + 32'(sent * 8), sent[0]);
      updReady = c[0];
      tick();
      sent += int'(m_last_cons);
    end
    chk("wrap_sent", sent, 20);
    drain();

    // Saturation: 17 branches into a 4-bit counter.
    do_reset();
    updReady = 1'b1;
    for (int c = 0; c < 17; c++) begin
      good_branch(32'h3000 + 32'(c * 4), 1);
      tick();
    end
    chk("sat_branchCount", branchCount, CMAX);
    drain();

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NL; i++) begin
        logic [PW-1:0] pc, tg, nx;
        bit tk;
        pc = $urandom & 32'hFFFF_FFFC;
        tg = $urandom & 32'hFFFF_FFFC;
        tk = $urandom_range(0, 1);
        nx = tk ? tg : pc + 32'd4;
        set_lane(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, pc, tk, tg,
                 $urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : nx);
      end
      updReady = (c % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tick();
    end
    drain();

    // Reset in the middle of a drain.
    do_reset();
    updReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      good_branch(32'h4000 + 32'(c * 4), 0);
      set_lane(1, 1, 1, 32'h4100 + 32'(c * 4), 1, 32'h4800, 1, 32'h4800);
      tick();
    end
    clear_lanes(); updReady = 1'b1;
    tick(); tick();
    do_reset();
    chk("rst_updValid", updValid, 0);
    chk("rst_branchCount", branchCount, 0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
